// File: rtl/game_pkg.sv
// game_pkg: shared lane geometry and judgement classes for the falling-tile game
package game_pkg;
  localparam int NUM_LANES = 4;
  localparam int SCREEN_H = 480;
  localparam int LANE_W = 160;
  localparam int TILE_H = 100;
  localparam logic [1:0] J_NONE = 2'd0;
  localparam logic [1:0] J_BAD = 2'd1;
  localparam logic [1:0] J_GOOD = 2'd2;
  localparam logic [1:0] J_PERFECT = 2'd3;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stable-time debounce and one-cycle rising-edge press
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input logic clk,
  input logic reset,
  input logic b,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic s0, s1, db, db_q;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      db <= 1'b0;
      db_q <= 1'b0;
      cnt <= '0;
    end else begin
      s0 <= b;
      s1 <= s0;
      db_q <= db;
      if (s1 == db) cnt <= '0;
      else if (cnt == CW'(DB_CYCLES - 1)) begin
        db <= s1;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  assign press = db & ~db_q;
endmodule

// File: rtl/hit_judge.sv
// hit_judge: per-lane press judgement, miss detection, lockout, saturating score and combo
module hit_judge
  import game_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int TILE_H = game_pkg::TILE_H,
  parameter int HIT_ROW = 400,
  parameter int PERF_TOL = 8,
  parameter int GOOD_TOL = 24,
  parameter int MISS_Y = SCREEN_H
) (
  input logic clk,
  input logic reset,
  input logic b1,
  input logic b2,
  input logic b3,
  input logic b4,
  input logic [9:0] t1,
  input logic [9:0] t2,
  input logic [9:0] t3,
  input logic [9:0] t4,
  output logic [NUM_LANES-1:0] hit,
  output logic [NUM_LANES-1:0] perfect,
  output logic [NUM_LANES-1:0] miss,
  output logic [NUM_LANES-1:0] clr,
  output logic [14:0] scores,
  output logic [7:0] combo
);
  logic [NUM_LANES-1:0] b, press, hv, pv, bad, mis;
  logic [NUM_LANES-1:0][9:0] t;
  logic [3:0] add, nh;
  logic [15:0] ssum;
  logic [8:0] csum;
  assign b = {b4, b3, b2, b1};
  assign t = {t4, t3, t2, t1};
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [10:0] d, ad;
    logic [9:0] pt;
    logic lk;
    logic [1:0] c;
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk(clk),
      .reset(reset),
      .b(b[i]),
      .press(press[i])
    );
    assign d = {1'b0, t[i]} + 11'(TILE_H) - 11'(HIT_ROW);
    assign ad = d[10] ? -d : d;
    assign c = !press[i] ? J_NONE
             : (lk || t[i] == '0 || ad > 11'(GOOD_TOL)) ? J_BAD
             : ad <= 11'(PERF_TOL) ? J_PERFECT : J_GOOD;
    assign hv[i] = c == J_GOOD || c == J_PERFECT;
    assign pv[i] = c == J_PERFECT;
    assign bad[i] = c == J_BAD;
    assign mis[i] = t[i] == 10'(MISS_Y) && pt != 10'(MISS_Y) && !lk;
    always_ff @(posedge clk)
      if (reset) begin
        pt <= '0;
        lk <= 1'b0;
      end else begin
        pt <= t[i];
        lk <= hv[i] || mis[i] || (lk && t[i] != '0);
      end
  end
  always_comb begin
    add = '0;
    nh = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      add = add + 4'(hv[k]) + 4'(pv[k]);
      nh = nh + 4'(hv[k]);
    end
    ssum = 16'(scores) + 16'(add);
    csum = 9'(combo) + 9'(nh);
  end
  always_ff @(posedge clk)
    if (reset) begin
      hit <= '0;
      perfect <= '0;
      miss <= '0;
      clr <= '0;
      scores <= '0;
      combo <= '0;
    end else begin
      hit <= hv;
      perfect <= pv;
      miss <= mis;
      clr <= hv | mis;
      scores <= ssum > 16'd32767 ? 15'd32767 : ssum[14:0];
      combo <= |(bad | mis) ? 8'd0 : csum > 9'd255 ? 8'd255 : csum[7:0];
    end
endmodule
